// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial unsigned subtractor, diff = a - b - bi.
// Resolves one bit per clock, LSB first, through a single registered borrow.
// A start/busy/done handshake frames each WIDTH-cycle operation.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bi,
  output logic [WIDTH-1:0] diff,
  output logic             bo,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  // Count value on the edge that resolves the MSB.
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             borrow;
  logic [CW-1:0]    count;

  logic x;
  logic y;
  logic d;
  logic borrow_nxt;

  // Full-subtractor cell on the current LSBs and the stored borrow.
  assign x          = a_sh[0];
  assign y          = b_sh[0];
  assign d          = x ^ y ^ borrow;
  assign borrow_nxt = (~x & y) | (~(x ^ y) & borrow);

  // Sequencer and datapath: capture on start, shift WIDTH times, pulse done.
  // NOTE: every register here uses <= so all of them sample pre-edge values;
  // a blocking '=' would let the shifted operand feed the same-edge borrow.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      borrow <= 1'b0;
      count  <= '0;
      diff   <= '0;
      bo     <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh   <= a;
            b_sh   <= b;
            borrow <= bi;
            count  <= '0;
            busy   <= 1'b1;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          borrow <= borrow_nxt;
          diff   <= {d, diff[WIDTH-1:1]};
          if (count == LAST) begin
            // Hold count at its last value so it never wraps mid-operation.
            bo    <= borrow_nxt;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            count <= count + 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: self-checking bench for serial_subtractor (WIDTH=4).
// Expected results come from plain integer arithmetic on the operands.
module tb_serial_subtractor;

  localparam int WIDTH = 4;
  localparam int MOD   = 1 << WIDTH;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             bi = 1'b0;
  logic [WIDTH-1:0] diff;
  logic             bo;
  logic             busy;
  logic             done;

  int checks = 0;
  int errors = 0;

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .bi   (bi),
    .diff (diff),
    .bo   (bo),
    .busy (busy),
    .done (done)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: unsigned subtraction with borrow, modulo 2^WIDTH.
  function automatic logic [WIDTH-1:0] ref_diff(input int av, input int bv, input int biv);
    int r;
    r = av - bv - biv;
    return WIDTH'((r + 2 * MOD) % MOD);
  endfunction

  function automatic logic ref_bo(input int av, input int bv, input int biv);
    return (av < bv + biv);
  endfunction

  // Advance one cycle; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Launch one operation and observe it until its done pulse (bounded).
  // With noise set, operands and start are scrambled while the unit is busy.
  // Returns in the first IDLE cycle after DONE.
  task automatic run_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                        input logic biv, input bit noise,
                        output logic [WIDTH-1:0] d_o, output logic bo_o,
                        output int lat, output int busy_n, output int done_n,
                        output int overlap_n);
    a = av; b = bv; bi = biv; start = 1'b1;
    step();
    start = 1'b0;
    lat = 0; busy_n = 0; done_n = 0; overlap_n = 0;
    d_o = 'x; bo_o = 1'bx;
    for (int i = 1; i <= 3 * WIDTH + 4; i++) begin
      if (busy) busy_n++;
      if (busy && done) overlap_n++;
      if (noise) begin
        a  = WIDTH'($urandom);
        b  = WIDTH'($urandom);
        bi = 1'($urandom);
        start = (busy || done) ? 1'($urandom) : 1'b0;
      end
      if (done) begin
        done_n++;
        lat  = i;
        d_o  = diff;
        bo_o = bo;
        step();
        start = 1'b0;
        break;
      end
      step();
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; a = 4'd9; b = 4'd3;
    step(); step(); step();
    checks++;
    if ({diff, bo, busy, done} !== '0) begin
      errors++;
      $display("FAIL reset_state: diff=%0h bo=%b busy=%b done=%b, required all 0", diff, bo, busy, done);
    end
    // start held through reset release edge only while rst is high: no op starts.
    start = 1'b0; rst = 1'b0;
    step();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL start_during_reset: busy=%b required 0", busy);
    end
  endtask

  task automatic test_directed();
    logic [WIDTH-1:0] d_o; logic bo_o; int lat, bn, dn, ov;
    logic [WIDTH-1:0] ta [3] = '{4'd9, 4'd0, 4'd15};
    logic [WIDTH-1:0] tb [3] = '{4'd3, 4'd0, 4'd15};
    logic             tbi[3] = '{1'b0, 1'b1, 1'b0};
    logic [WIDTH-1:0] ed [3] = '{4'd6, 4'hF, 4'd0};
    logic             eb [3] = '{1'b0, 1'b1, 1'b0};
    for (int k = 0; k < 3; k++) begin
      run_op(ta[k], tb[k], tbi[k], 1'b0, d_o, bo_o, lat, bn, dn, ov);
      checks++;
      if (d_o !== ed[k] || bo_o !== eb[k]) begin
        errors++;
        $display("FAIL directed_%0d: diff=%0h bo=%b, required diff=%0h bo=%b", k, d_o, bo_o, ed[k], eb[k]);
      end
      checks++;
      if (lat != WIDTH + 1 || bn != WIDTH || dn != 1 || ov != 0) begin
        errors++;
        $display("FAIL directed_timing_%0d: latency=%0d busy_cycles=%0d dones=%0d overlap=%0d, required %0d %0d 1 0",
                 k, lat, bn, dn, ov, WIDTH + 1, WIDTH);
      end
    end
  endtask

  task automatic test_hold();
    logic [WIDTH-1:0] d_o; logic bo_o; int lat, bn, dn, ov;
    int bad;
    run_op(4'd3, 4'd9, 1'b0, 1'b0, d_o, bo_o, lat, bn, dn, ov);
    checks++;
    if (d_o !== 4'hA || bo_o !== 1'b1 || dn != 1) begin
      errors++;
      $display("FAIL borrow_case: diff=%0h bo=%b dones=%0d, required diff=a bo=1 dones=1", d_o, bo_o, dn);
    end
    bad = 0;
    a = 4'd1; b = 4'd1; bi = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (diff !== 4'hA || bo !== 1'b1 || done !== 1'b0 || busy !== 1'b0) bad++;
      step();
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL result_hold: %0d idle cycles lost the result, required 0", bad);
    end
  endtask

  task automatic test_sweep();
    logic [WIDTH-1:0] d_o; logic bo_o; int lat, bn, dn, ov;
    int bad_res, bad_tim;
    bad_res = 0; bad_tim = 0;
    for (int av = 0; av < MOD; av++)
      for (int bv = 0; bv < MOD; bv++)
        for (int cv = 0; cv < 2; cv++) begin
          run_op(WIDTH'(av), WIDTH'(bv), 1'(cv), 1'b0, d_o, bo_o, lat, bn, dn, ov);
          checks++;
          if (d_o !== ref_diff(av, bv, cv) || bo_o !== ref_bo(av, bv, cv)) begin
            bad_res++;
            errors++;
            if (bad_res <= 8)
              $display("FAIL sweep_result a=%0d b=%0d bi=%0d: diff=%0h bo=%b, required diff=%0h bo=%b",
                       av, bv, cv, d_o, bo_o, ref_diff(av, bv, cv), ref_bo(av, bv, cv));
          end
          checks++;
          if (dn != 1 || lat != WIDTH + 1 || ov != 0) begin
            bad_tim++;
            errors++;
            if (bad_tim <= 8)
              $display("FAIL sweep_timing a=%0d b=%0d bi=%0d: dones=%0d latency=%0d overlap=%0d, required 1 %0d 0",
                       av, bv, cv, dn, lat, ov, WIDTH + 1);
          end
        end
  endtask

  task automatic test_ignored_start();
    int dones, busy_bad;
    dones = 0; busy_bad = 0;
    a = 4'd5; b = 4'd2; bi = 1'b1; start = 1'b1;                 // cycle N
    step(); start = 1'b0; a = 4'd12; b = 4'd13; bi = 1'b1;         // N+1
    if (done) dones++;
    if (busy !== 1'b1) busy_bad++;
    step(); start = 1'b1; a = 4'd1; b = 4'd14; bi = 1'b0;          // N+2
    if (done) dones++;
    if (busy !== 1'b1) busy_bad++;
    step(); start = 1'b0;                                          // N+3
    if (done) dones++;
    if (busy !== 1'b1) busy_bad++;
    step();                                                        // N+4
    if (done) dones++;
    if (busy !== 1'b1) busy_bad++;
    step();                                                        // N+5
    if (done) dones++;
    checks++;
    if (done !== 1'b1 || diff !== 4'd2 || bo !== 1'b0) begin
      errors++;
      $display("FAIL ignored_start_result: done=%b diff=%0h bo=%b, required done=1 diff=2 bo=0", done, diff, bo);
    end
    start = 1'b1; a = 4'd7; b = 4'd1; bi = 1'b0;
    step();                                                        // N+6
    if (done) dones++;
    checks++;
    if (dones != 1 || busy_bad != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL ignored_start_pulses: dones=%0d busy_gaps=%0d busy_at_idle=%b, required 1 0 0", dones, busy_bad, busy);
    end
    a = 4'd8; b = 4'd3; bi = 1'b0;                                 // start still 1: accepted here
    step(); start = 1'b0;                                          // N+7
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL restart_accept: busy=%b required 1", busy);
    end
    step(); step(); step(); step();                                // N+11
    checks++;
    if (done !== 1'b1 || diff !== 4'd5 || bo !== 1'b0) begin
      errors++;
      $display("FAIL restart_result: done=%b diff=%0h bo=%b, required done=1 diff=5 bo=0", done, diff, bo);
    end
    step();
  endtask

  task automatic test_reset_mid();
    logic [WIDTH-1:0] d_o; logic bo_o; int lat, bn, dn, ov;
    logic [WIDTH-1:0] av, bv; logic cv;
    int stray;
    a = 4'd9; b = 4'd3; bi = 1'b0; start = 1'b1;                   // N
    step(); start = 1'b0;                                          // N+1
    step();                                                        // N+2
    step(); rst = 1'b1;                                            // N+3
    step(); rst = 1'b0;                                            // N+4
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || diff !== '0 || bo !== 1'b0) begin
      errors++;
      $display("FAIL reset_abort: busy=%b done=%b diff=%0h bo=%b, required all 0", busy, done, diff, bo);
    end
    stray = 0;
    for (int i = 0; i < 10; i++) begin
      if (done || busy) stray++;
      step();
    end
    checks++;
    if (stray != 0) begin
      errors++;
      $display("FAIL reset_no_done: %0d active cycles after abort, required 0", stray);
    end
    av = WIDTH'($urandom); bv = WIDTH'($urandom); cv = 1'($urandom);
    run_op(av, bv, cv, 1'b0, d_o, bo_o, lat, bn, dn, ov);
    checks++;
    if (d_o !== ref_diff(av, bv, cv) || bo_o !== ref_bo(av, bv, cv) || lat != WIDTH + 1 || dn != 1) begin
      errors++;
      $display("FAIL post_reset_op a=%0d b=%0d bi=%0d: diff=%0h bo=%b latency=%0d, required diff=%0h bo=%b latency=%0d",
               av, bv, cv, d_o, bo_o, lat, ref_diff(av, bv, cv), ref_bo(av, bv, cv), WIDTH + 1);
    end
  endtask

  task automatic test_random_noise();
    logic [WIDTH-1:0] d_o; logic bo_o; int lat, bn, dn, ov;
    logic [WIDTH-1:0] av, bv; logic cv;
    int gap;
    for (int k = 0; k < 60; k++) begin
      av = WIDTH'($urandom); bv = WIDTH'($urandom); cv = 1'($urandom);
      run_op(av, bv, cv, 1'b1, d_o, bo_o, lat, bn, dn, ov);
      checks++;
      if (d_o !== ref_diff(av, bv, cv) || bo_o !== ref_bo(av, bv, cv) ||
          lat != WIDTH + 1 || bn != WIDTH || dn != 1 || ov != 0) begin
        errors++;
        $display("FAIL random_%0d a=%0d b=%0d bi=%0d: diff=%0h bo=%b lat=%0d busy=%0d dones=%0d, required diff=%0h bo=%b lat=%0d busy=%0d dones=1",
                 k, av, bv, cv, d_o, bo_o, lat, bn, dn, ref_diff(av, bv, cv), ref_bo(av, bv, cv), WIDTH + 1, WIDTH);
      end
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) step();
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_hold();
    test_sweep();
    test_ignored_start();
    test_reset_mid();
    test_random_noise();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial, multi-cycle subtractor for the SUMADOR arithmetic group, and the counterpart to the combinational ripple adder. It computes `diff = a - b - bi` for WIDTH-bit operands one bit per clock, LSB first, using a single registered borrow. The start/busy/done handshake lets it serve as a small-area subtract unit beside the adder datapath.

## Interface
- `WIDTH`, default 4: operand and result width in bits. Minimum 2.
- `clk` input 1: single clock. All state changes on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: request a subtraction. Sampled only in IDLE.
- `a` input WIDTH: minuend. Captured on the accepted `start`.
- `b` input WIDTH: subtrahend. Captured on the accepted `start`.
- `bi` input 1: borrow in. Captured on the accepted `start`.
- `diff` output WIDTH: difference. Valid from the `done` cycle and held until the next accepted `start`.
- `bo` output 1: borrow out. 1 when `a < b + bi` (unsigned). Same validity as `diff`.
- `busy` output 1: high while bits are being processed.
- `done` output 1: one-cycle pulse when the result is valid.

## Operation
- States:
  - IDLE: waits for `start`.
  - SHIFT: processes one bit per cycle.
  - DONE: presents the result for one cycle.
- IDLE with `start=1`: on that edge, load the shift registers A←`a` and B←`b`, the borrow flop←`bi`, and count←0. Next state is SHIFT.
- IDLE with `start=0`: stay in IDLE. All registers hold.
- SHIFT, each cycle, with x=A[0], y=B[0], c=borrow:
  - d = x ^ y ^ c.
  - next borrow = (~x & y) | (~(x ^ y) & c).
  - Shift A and B right by 1.
  - Shift d into the MSB of the `diff` register. After WIDTH shifts, `diff[i]` holds bit i.
  - count increments.
  - When count = WIDTH-1, next state is DONE.
- DONE: `done`=1. `bo` equals the final borrow. Next state is IDLE unconditionally.
- `start` asserted in SHIFT or DONE is ignored. It is neither queued nor restarted. A new request must be presented in IDLE.
- `a`, `b`, `bi` may change freely after the accepting edge. Only the captured copies are used.
- Arithmetic is unsigned modulo 2^WIDTH: `diff` = (a - b - bi) mod 2^WIDTH. `bo` is the borrow out of the MSB.
- count width is ceil(log2(WIDTH)) bits. It never wraps during an operation.
- `rst`=1 takes priority over everything, including an active operation. On the next edge:
  - state←IDLE.
  - `diff`←0, `bo`←0, `busy`←0, `done`←0.
  - count←0, A←0, B←0, borrow←0.
  - Any operation in progress is aborted with no `done`.
- `start` and `rst` in the same cycle: reset wins and the request is dropped.

## Timing
- Let cycle N be the cycle in which `start`=1 is sampled in IDLE.
- Cycles N+1 through N+WIDTH: state SHIFT, `busy`=1. Bit i is resolved on the edge ending cycle N+1+i.
- Cycle N+WIDTH+1: state DONE. `done`=1, `busy`=0, `diff` and `bo` valid.
- Cycle N+WIDTH+2: IDLE. Earliest cycle in which the next `start` is accepted.
- Latency from `start` to `done` is WIDTH+1 cycles, which is 5 for WIDTH=4.
- Throughput is one operation per WIDTH+2 cycles.
- `diff` changes during SHIFT (partial shifting). Consumers must read it only at or after `done`.
- `busy` and `done` are registered outputs, never high together. `done` is exactly one cycle wide.

## Test plan
- Reset, then `a`=9, `b`=3, `bi`=0, `start` pulse at cycle N -> `busy` high in cycles N+1..N+4; `done`=1 at N+5 with `diff`=6, `bo`=0.
- `a`=3, `b`=9, `bi`=0 -> `diff`=0xA, `bo`=1 at `done`. Values hold for 10 idle cycles afterwards.
- `a`=0, `b`=0, `bi`=1 -> `diff`=0xF, `bo`=1. Then `a`=15, `b`=15, `bi`=0 -> `diff`=0, `bo`=0.
- Exhaustive sweep of all a, b, bi (512 operations, back-to-back `start` at the first IDLE cycle) -> every result matches (a-b-bi) mod 16, `bo`=(a<b+bi), and each operation has exactly one `done`.
- `start` re-pulsed at N+2 and at N+5 with different operands, plus operand changes at N+1 -> only the first request completes, with the original result and one `done`. A `start` at N+6 is accepted.
- `rst` asserted at N+3 mid-operation -> next cycle `busy`=0, `done`=0, `diff`=0, `bo`=0. No `done` appears. A fresh `start` afterwards produces the correct result at 5-cycle latency.
